// File: rtl/data_bus_arbiter_if.sv
// Bundle between the arbiter, the accelerator FIFO pairs and the data RAM.
// master = arbiter side, slave = FIFO/RAM side.
interface data_bus_arbiter_if #(
    parameter int DATA_W = 128,
    parameter int NUM_CH = 3,
    parameter int CH_W   = 2,
    parameter int PTR_W  = 8
);
    logic [NUM_CH-1:0]        ch_enable;
    logic [NUM_CH-1:0]        to_empty;
    logic [NUM_CH-1:0]        to_full;
    logic [NUM_CH-1:0]        from_empty;
    logic [NUM_CH-1:0]        from_full;
    logic [NUM_CH*DATA_W-1:0] from_acc_data;
    logic [DATA_W-1:0]        ram_rd_data;
    logic [NUM_CH-1:0]        put_req;
    logic [NUM_CH-1:0]        get_req;
    logic [DATA_W-1:0]        to_acc_data;
    logic                     ram_read_enable;
    logic                     ram_write_enable;
    logic [CH_W+PTR_W:0]      ram_addr;
    logic [DATA_W-1:0]        ram_wr_data;
    logic [NUM_CH-1:0]        grant;
    logic                     busy;

    modport master (
        input  ch_enable, to_empty, to_full,
        input  from_empty, from_full,
        input  from_acc_data, ram_rd_data,
        output put_req, get_req, to_acc_data,
        output ram_read_enable, ram_write_enable,
        output ram_addr, ram_wr_data,
        output grant, busy
    );

    modport slave (
        output ch_enable, to_empty, to_full,
        output from_empty, from_full,
        output from_acc_data, ram_rd_data,
        input  put_req, get_req, to_acc_data,
        input  ram_read_enable, ram_write_enable,
        input  ram_addr, ram_wr_data,
        input  grant, busy
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter moving bounded bursts between accelerator FIFOs
// and a shared data RAM port, two cycles per word.
module data_bus_arbiter #(
    parameter int DATA_W    = 128,
    parameter int NUM_CH    = 3,
    parameter int CH_W      = 2,
    parameter int PTR_W     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    data_bus_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic FILL  = 1'b0;
    localparam logic DRAIN = 1'b1;

    typedef enum logic [1:0] {ARB, ISSUE, COMPLETE} state_t;

    state_t            state;
    logic [NUM_CH-1:0] grant_q;
    logic [CH_W-1:0]   gidx;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   pick;
    logic              dir;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr [NUM_CH];
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] cand_dir;
    logic              found;
    logic              issue_ok;

    // A full from-FIFO or an empty to-FIFO is the most urgent case.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i]     = bus.ch_enable[i];
            cand_dir[i] = DRAIN;
            if (bus.from_full[i])        cand_dir[i] = DRAIN;
            else if (bus.to_empty[i])    cand_dir[i] = FILL;
            else if (!bus.from_empty[i]) cand_dir[i] = DRAIN;
            else if (!bus.to_full[i])    cand_dir[i] = FILL;
            else                         cand[i]     = 1'b0;
        end
    end

    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    assign issue_ok = bus.ch_enable[gidx]
                    && (count < CNT_W'(BURST_LEN))
                    && ((dir == FILL) ? !bus.to_full[gidx]
                                      : !bus.from_empty[gidx]);

    always_comb begin
        bus.put_req          = '0;
        bus.get_req          = '0;
        bus.to_acc_data      = '0;
        bus.ram_read_enable  = 1'b0;
        bus.ram_write_enable = 1'b0;
        bus.ram_addr         = '0;
        bus.ram_wr_data      = '0;
        unique case (state)
            ISSUE: begin
                if (issue_ok) begin
                    if (dir == FILL) begin
                        bus.ram_read_enable = 1'b1;
                        bus.ram_addr = {gidx, 1'b0, rd_ptr[gidx]};
                    end else begin
                        bus.get_req = grant_q;
                    end
                end
            end
            COMPLETE: begin
                if (dir == FILL) begin
                    bus.put_req     = grant_q;
                    bus.to_acc_data = bus.ram_rd_data;
                end else begin
                    bus.ram_write_enable = 1'b1;
                    bus.ram_addr    = {gidx, 1'b1, wr_ptr[gidx]};
                    bus.ram_wr_data =
                        bus.from_acc_data[int'(gidx)*DATA_W +: DATA_W];
                end
            end
            default: ;
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.busy  = |grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            grant_q    <= '0;
            gidx       <= '0;
            dir        <= FILL;
            last_grant <= CH_W'(NUM_CH - 1);
            count      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            unique case (state)
                ARB: begin
                    if (found) begin
                        grant_q    <= NUM_CH'(1) << pick;
                        gidx       <= pick;
                        dir        <= cand_dir[pick];
                        last_grant <= pick;
                        count      <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_ok) begin
                        if (dir == FILL)
                            rd_ptr[gidx] <= rd_ptr[gidx] + 1'b1;
                        state <= COMPLETE;
                    end else begin
                        grant_q <= '0;
                        state   <= ARB;
                    end
                end
                COMPLETE: begin
                    if (dir == DRAIN)
                        wr_ptr[gidx] <= wr_ptr[gidx] + 1'b1;
                    count <= count + 1'b1;
                    state <= ISSUE;
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: default build plus a PTR_W=2 build
// for pointer wrap.
module tb_data_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_bus_arbiter_if #(.DATA_W(128), .NUM_CH(3), .CH_W(2),
                          .PTR_W(8)) b ();
    data_bus_arbiter_if #(.DATA_W(128), .NUM_CH(3), .CH_W(2),
                          .PTR_W(2)) b2 ();

    data_bus_arbiter #(.DATA_W(128), .NUM_CH(3), .CH_W(2),
                       .PTR_W(8), .BURST_LEN(4))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b));
    data_bus_arbiter #(.DATA_W(128), .NUM_CH(3), .CH_W(2),
                       .PTR_W(2), .BURST_LEN(4))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b2));

    int vecs = 0;
    int errs = 0;
    logic [127:0] sl [3];

    // {busy, grant, put_req, get_req, rd_en, wr_en, ram_addr}
    wire [22:0] c0 = {b.busy, b.grant, b.put_req, b.get_req,
                      b.ram_read_enable, b.ram_write_enable, b.ram_addr};
    wire [16:0] c1 = {b2.busy, b2.grant, b2.put_req, b2.get_req,
                      b2.ram_read_enable, b2.ram_write_enable, b2.ram_addr};

    function automatic logic [127:0] pat(input logic [10:0] a);
        return {64'hFEEDFACE0BADCAFE, 53'h0, a};
    endfunction

    always @(posedge clk)
        if (b.ram_read_enable) b.ram_rd_data <= pat(b.ram_addr);
    always @(posedge clk)
        if (b2.ram_read_enable) b2.ram_rd_data <= pat({6'h0, b2.ram_addr});

    task automatic idle_inputs;
        b.ch_enable = '0;  b.to_empty = '0;  b.to_full = '0;
        b.from_empty = '1; b.from_full = '0;
        b2.ch_enable = '0; b2.to_empty = '0; b2.to_full = '0;
        b2.from_empty = '1; b2.from_full = '0;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset;
        apply_reset();
        b.ch_enable = 3'b111;  b.to_empty = 3'b111;
        b2.ch_enable = 3'b111; b2.to_empty = 3'b111;
        @(negedge clk);
        vecs++;
        if (c0 !== 23'h0) begin
            errs++; $display("FAIL reset_ctl got %h want 0", c0);
        end
        vecs++;
        if (b.to_acc_data !== 128'h0 || b.ram_wr_data !== 128'h0) begin
            errs++; $display("FAIL reset_data got %h/%h want 0",
                             b.to_acc_data, b.ram_wr_data);
        end
        vecs++;
        if (c1 !== 17'h0) begin
            errs++; $display("FAIL reset_ctl2 got %h want 0", c1);
        end
        idle_inputs();
    endtask

    task automatic test_fill_burst;
        logic [22:0] e;
        apply_reset();
        b.ch_enable = 3'b001; b.to_empty = 3'b001; b.from_empty = 3'b000;
        rst_n = 1'b1;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            e = {1'b1, 3'b001, 6'b0, 1'b1, 1'b0, 11'(w)};
            vecs++;
            if (c0 !== e) begin
                errs++; $display("FAIL fill_issue w=%0d got %h want %h",
                                 w, c0, e);
            end
            @(negedge clk);
            e = {1'b1, 3'b001, 3'b001, 3'b0, 2'b0, 11'h0};
            vecs++;
            if (c0 !== e || b.to_acc_data !== pat(11'(w))) begin
                errs++; $display("FAIL fill_put w=%0d got %h/%h want %h/%h",
                                 w, c0, b.to_acc_data, e, pat(11'(w)));
            end
        end
        @(negedge clk);
        vecs++;
        if (c0 !== {1'b1, 3'b001, 19'h0}) begin
            errs++; $display("FAIL fill_term got %h want %h",
                             c0, {1'b1, 3'b001, 19'h0});
        end
        @(negedge clk);
        vecs++;
        if (c0 !== 23'h0) begin
            errs++; $display("FAIL fill_arb got %h want 0", c0);
        end
        idle_inputs();
    endtask

    task automatic test_drain_rr;
        int order [4] = '{0, 1, 2, 0};
        int base  [4] = '{0, 0, 0, 4};
        logic [2:0]  oh;
        logic [22:0] e;
        apply_reset();
        b.ch_enable = 3'b111; b.from_full = 3'b111; b.from_empty = 3'b000;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            oh = 3'(1 << order[k]);
            for (int w = 0; w < 4; w++) begin
                @(negedge clk);
                e = {1'b1, oh, 3'b0, oh, 2'b0, 11'h0};
                vecs++;
                if (c0 !== e) begin
                    errs++; $display("FAIL drain_get k=%0d w=%0d got %h want %h",
                                     k, w, c0, e);
                end
                @(negedge clk);
                e = {1'b1, oh, 6'b0, 1'b0, 1'b1,
                     2'(order[k]), 1'b1, 8'(base[k] + w)};
                vecs++;
                if (c0 !== e || b.ram_wr_data !== sl[order[k]]) begin
                    errs++; $display("FAIL drain_wr k=%0d w=%0d got %h/%h want %h/%h",
                                     k, w, c0, b.ram_wr_data, e, sl[order[k]]);
                end
            end
            @(negedge clk);
            vecs++;
            if (c0 !== {1'b1, oh, 19'h0}) begin
                errs++; $display("FAIL drain_term k=%0d got %h want %h",
                                 k, c0, {1'b1, oh, 19'h0});
            end
            @(negedge clk);
            if (k == 3) b.ch_enable = 3'b000;
            vecs++;
            if (c0 !== 23'h0) begin
                errs++; $display("FAIL drain_arb k=%0d got %h want 0", k, c0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_fill_stop;
        logic [22:0] e;
        apply_reset();
        b.ch_enable = 3'b010; b.from_empty = 3'b111;
        rst_n = 1'b1;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            e = {1'b1, 3'b010, 6'b0, 1'b1, 1'b0, 2'd1, 1'b0, 8'(w)};
            vecs++;
            if (c0 !== e) begin
                errs++; $display("FAIL stop_issue w=%0d got %h want %h",
                                 w, c0, e);
            end
            @(negedge clk);
            e = {1'b1, 3'b010, 3'b010, 3'b0, 2'b0, 11'h0};
            vecs++;
            if (c0 !== e || b.to_acc_data !== pat({2'd1, 1'b0, 8'(w)})) begin
                errs++; $display("FAIL stop_put w=%0d got %h/%h want %h",
                                 w, c0, b.to_acc_data, e);
            end
            if (w == 1) b.to_full = 3'b010;
        end
        @(negedge clk);
        vecs++;
        if (c0 !== {1'b1, 3'b010, 19'h0}) begin
            errs++; $display("FAIL stop_term got %h want %h",
                             c0, {1'b1, 3'b010, 19'h0});
        end
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            vecs++;
            if (c0 !== 23'h0) begin
                errs++; $display("FAIL stop_idle n=%0d got %h want 0", n, c0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_enable_drop;
        apply_reset();
        b.ch_enable = 3'b001; b.from_full = 3'b001; b.from_empty = 3'b000;
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (c0 !== {1'b1, 3'b001, 3'b0, 3'b001, 2'b0, 11'h0}) begin
            errs++; $display("FAIL drop_get got %h want %h",
                             c0, {1'b1, 3'b001, 3'b0, 3'b001, 2'b0, 11'h0});
        end
        @(negedge clk);
        b.ch_enable = 3'b000;
        #1;
        vecs++;
        if (c0 !== {1'b1, 3'b001, 6'b0, 2'b01, 11'h100}
            || b.ram_wr_data !== sl[0]) begin
            errs++; $display("FAIL drop_wr got %h/%h want %h/%h", c0,
                             b.ram_wr_data,
                             {1'b1, 3'b001, 6'b0, 2'b01, 11'h100}, sl[0]);
        end
        @(negedge clk);
        vecs++;
        if (c0 !== {1'b1, 3'b001, 19'h0}) begin
            errs++; $display("FAIL drop_term got %h want %h",
                             c0, {1'b1, 3'b001, 19'h0});
        end
        @(negedge clk);
        vecs++;
        if (c0 !== 23'h0) begin
            errs++; $display("FAIL drop_release got %h want 0", c0);
        end
        idle_inputs();
    endtask

    task automatic test_ptr_wrap;
        logic [16:0] e;
        apply_reset();
        b2.ch_enable = 3'b001; b2.to_empty = 3'b001; b2.from_empty = 3'b000;
        rst_n = 1'b1;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            e = {1'b1, 3'b001, 6'b0, 1'b1, 1'b0, 5'(w % 4)};
            vecs++;
            if (c1 !== e) begin
                errs++; $display("FAIL wrap_issue w=%0d got %h want %h",
                                 w, c1, e);
            end
            @(negedge clk);
            e = {1'b1, 3'b001, 3'b001, 3'b0, 2'b0, 5'h0};
            vecs++;
            if (c1 !== e || b2.to_acc_data !== pat(11'(w % 4))) begin
                errs++; $display("FAIL wrap_put w=%0d got %h/%h want %h",
                                 w, c1, b2.to_acc_data, e);
            end
            if (w == 5) b2.ch_enable = 3'b000;
            if (w == 3 || w == 5) begin
                @(negedge clk);
                vecs++;
                if (c1 !== {1'b1, 3'b001, 13'h0}) begin
                    errs++; $display("FAIL wrap_term w=%0d got %h want %h",
                                     w, c1, {1'b1, 3'b001, 13'h0});
                end
                @(negedge clk);
                vecs++;
                if (c1 !== 17'h0 || c0 !== 23'h0) begin
                    errs++; $display("FAIL wrap_arb w=%0d got %h/%h want 0",
                                     w, c1, c0);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        apply_reset();
        b.ch_enable = 3'b001; b.to_empty = 3'b001; b.from_empty = 3'b000;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vecs++;
        if (b.put_req !== 3'b001) begin
            errs++; $display("FAIL mid_put got %b want 001", b.put_req);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (c0 !== 23'h0 || b.to_acc_data !== 128'h0) begin
            errs++; $display("FAIL mid_clear got %h/%h want 0",
                             c0, b.to_acc_data);
        end
        b.ch_enable = 3'b011; b.to_empty = 3'b011;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (c0 !== {1'b1, 3'b001, 6'b0, 2'b10, 11'h0}) begin
            errs++; $display("FAIL mid_restart got %h want %h",
                             c0, {1'b1, 3'b001, 6'b0, 2'b10, 11'h0});
        end
        idle_inputs();
    endtask

    initial begin
        sl[0] = {32{4'hA}};
        sl[1] = {32{4'hB}};
        sl[2] = {32{4'hC}};
        b.from_acc_data  = {sl[2], sl[1], sl[0]};
        b2.from_acc_data = {sl[2], sl[1], sl[0]};
        idle_inputs();
        test_reset();
        test_fill_burst();
        test_drain_rr();
        test_fill_stop();
        test_enable_drop();
        test_ptr_wrap();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
